io_bridge: RTL

- Memory-mapped I/O slave directly downstream of the MEM stage; serves every access with addr[31]=1 (data RAM serves addr[31]=0).
- Owns the LED output register, a synchronised and debounced 12-bit switch input, a free-running timer with compare match, and a sticky status register.
- Reads are combinational, so MEM returns the value in the same cycle. Writes commit on the rising clock edge.

---
 rtl/io_bridge_pkg.sv | 25 ++
 rtl/io_bridge_if.sv | 27 ++
 rtl/io_debounce.sv | 74 +++++++
 rtl/io_bridge.sv | 107 ++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared definitions for the memory-mapped I/O bridge: select bit, register
// offsets, debounce FSM states and the board data bus type.
package io_bridge_pkg;

    localparam int IO_BASE_BIT = 31;
    localparam int IO_DATA_W   = 12;

    typedef logic [IO_DATA_W-1:0] io_data_t;

    localparam logic [2:0] IO_LED    = 3'd0;
    localparam logic [2:0] IO_SW     = 3'd1;
    localparam logic [2:0] IO_TCNT   = 3'd2;
    localparam logic [2:0] IO_TCMP   = 3'd3;
    localparam logic [2:0] IO_STATUS = 3'd4;

    typedef enum logic {
        DB_STABLE = 1'b0,
        DB_COUNT  = 1'b1
    } db_state_e;

    function automatic logic [31:0] zext_data(input io_data_t d);
        return {{(32-IO_DATA_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/io_bridge_if.sv
// MEM-stage to I/O bridge access bus; the MEM stage is the master,
// io_bridge the slave. Read data is combinational from the slave.
interface io_bridge_if;

    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (
        output ce_i,
        output we_i,
        output addr_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  ce_i,
        input  we_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o
    );

endinterface

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus stability counter for the board switches.
// changed_o pulses in the cycle whose edge commits a value different from sw_o.
module io_debounce
    import io_bridge_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic     clk,
    input  logic     rst,
    input  io_data_t sw_raw_i,
    output io_data_t sw_o,
    output logic     changed_o
);

    localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

    io_data_t    s1_q, s2_q;
    io_data_t    cand_q, cand_d;
    io_data_t    sw_q, sw_d;
    logic [15:0] cnt_q, cnt_d;
    db_state_e   state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            sw_q    <= '0;
            cnt_q   <= '0;
            state_q <= DB_STABLE;
        end else begin
            s1_q    <= sw_raw_i;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        sw_d      = sw_q;
        changed_o = 1'b0;
        case (state_q)
            DB_STABLE: begin
                if (s2_q != sw_q) begin
                    cand_d  = s2_q;
                    cnt_d   = '0;
                    state_d = DB_COUNT;
                end
            end
            DB_COUNT: begin
                if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // A candidate that drifted back to the committed value still commits, silently.
                    sw_d      = cand_q;
                    changed_o = (cand_q != sw_q);
                    state_d   = DB_STABLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = DB_STABLE;
        endcase
    end

    assign sw_o = sw_q;

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped I/O slave for addr[31]=1: LEDs, debounced switches, sticky
// status and, when IO_TIMER_EN is defined, a free-running timer with compare.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter io_data_t    LED_RESET       = 12'h000
) (
    input  logic           clk,
    input  logic           rst,
    io_bridge_if.slave     bus,
    input  io_data_t       switch_raw,
    output io_data_t       led_o,
    output logic           irq_o
);

    logic        sel, wr;
    logic [2:0]  off;
    io_data_t    sw_val;
    logic        sw_changed;
    io_data_t    led_q, led_d;
    logic [1:0]  status_q, status_d, status_clr;
    logic        match;
    logic [31:0] tcnt_rd, tcmp_rd;
    logic        unused_bits;

    assign sel = bus.ce_i & bus.addr_i[IO_BASE_BIT];
    assign wr  = sel & bus.we_i;
    assign off = bus.addr_i[4:2];
    assign unused_bits = ^{bus.addr_i[30:5], bus.addr_i[1:0], bus.wdata_i[31:12]};

    io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .sw_raw_i  (switch_raw),
        .sw_o      (sw_val),
        .changed_o (sw_changed)
    );

`ifdef IO_TIMER_EN
    logic [31:0] tcnt_q, tcnt_d, tcmp_q, tcmp_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q <= '0;
            tcmp_q <= '1;
        end else begin
            tcnt_q <= tcnt_d;
            tcmp_q <= tcmp_d;
        end
    end

    always_comb begin
        tcnt_d = tcnt_q + 32'd1;
        tcmp_d = tcmp_q;
        if (wr && off == IO_TCNT) tcnt_d = bus.wdata_i;
        if (wr && off == IO_TCMP) tcmp_d = bus.wdata_i;
    end

    assign match   = (tcnt_q == tcmp_q);
    assign tcnt_rd = tcnt_q;
    assign tcmp_rd = tcmp_q;
`else
    assign match   = 1'b0;
    assign tcnt_rd = '0;
    assign tcmp_rd = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q    <= LED_RESET;
            status_q <= '0;
        end else begin
            led_q    <= led_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        led_d      = led_q;
        status_clr = '0;
        if (wr && off == IO_LED)    led_d      = bus.wdata_i[IO_DATA_W-1:0];
        if (wr && off == IO_STATUS) status_clr = bus.wdata_i[1:0];
        // Applying the sets after the clear lets a same-cycle event win over W1C.
        status_d = (status_q & ~status_clr) | {sw_changed, match};
    end

    always_comb begin
        bus.rdata_o = '0;
        if (sel && !bus.we_i) begin
            case (off)
                IO_LED:    bus.rdata_o = zext_data(led_q);
                IO_SW:     bus.rdata_o = zext_data(sw_val);
                IO_TCNT:   bus.rdata_o = tcnt_rd;
                IO_TCMP:   bus.rdata_o = tcmp_rd;
                IO_STATUS: bus.rdata_o = {30'd0, status_q};
                default:   bus.rdata_o = '0;
            endcase
        end
    end

    assign led_o = led_q;
    assign irq_o = status_q[0] | status_q[1];

endmodule
